// File: rtl/ats21_cmd_issuer.sv
// ATS21 command issuer: queued 32-bit instructions sent as HI/LO 16-bit beats, stat-checked with Nack retry; pop-to-rsp 4 cycles.
// Backpressure via o_cmd_ready (FIFO not full); optional alarm capture under `ATS21_ALARM_CAPTURE_EN.
module ats21_cmd_issuer #(
  parameter int CMD_DEPTH = 4,
  parameter int CLIENT    = 0,
  parameter int STAT_LAT  = 1,
  parameter int MAX_RETRY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  input  logic [31:0] i_cmd_data,
  output logic        o_cmd_ready,
  output logic        o_rsp_valid,
  output logic        o_rsp_ack,
  output logic [2:0]  o_rsp_opcode,
  output logic [1:0]  o_rsp_retries,
  output logic        o_busy,
  output logic        o_req,
  output logic [15:0] o_ctrl,
  input  logic [1:0]  i_stat,
  input  logic [23:0] i_alarm_data,
  output logic [23:0] o_alarm_flags,
  input  logic [23:0] i_alarm_clr
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = (STAT_LAT > 1) ? $clog2(STAT_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WAIT, S_GAP, S_DONE} state_t;

  logic [31:0]   r_fifo [CMD_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state, w_state_nxt;
  logic [31:0]   r_cmd;
  logic [1:0]    r_retries;
  logic          r_ack;
  logic [WW-1:0] r_wcnt;

  logic          r_req, r_rsp_valid, r_rsp_ack, r_busy;
  logic [15:0]   r_ctrl;
  logic [2:0]    r_rsp_opcode;
  logic [1:0]    r_rsp_retries;

  logic          w_req_nxt, w_rsp_valid_nxt, w_rsp_ack_nxt;
  logic [15:0]   w_ctrl_nxt;
  logic [2:0]    w_rsp_opcode_nxt;
  logic [1:0]    w_rsp_retries_nxt;

  logic          w_push, w_pop, w_stat_bit, w_last_wait, w_head_nop;
  logic [31:0]   w_head;
  logic [CW-1:0] w_count_nxt;
  logic          w_unused_stat;

  assign o_cmd_ready   = (r_count != CW'(CMD_DEPTH));
  assign w_push        = i_cmd_valid & o_cmd_ready;
  assign w_pop         = (r_state == S_IDLE) && (r_count != '0);
  assign w_head        = r_fifo[r_rd_ptr];
  assign w_head_nop    = (w_head[31:29] == 3'b000);
  assign w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
  assign w_stat_bit    = i_stat[CLIENT];
  assign w_unused_stat = ^i_stat;
  assign w_last_wait   = (r_state == S_WAIT) && (r_wcnt == WW'(STAT_LAT - 1));

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= i_cmd_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_pop && !w_head_nop) w_state_nxt = S_HI;
      S_HI:   w_state_nxt = S_LO;
      S_LO:   w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_last_wait) begin
          if (w_stat_bit || (r_retries == 2'(MAX_RETRY))) w_state_nxt = S_DONE;
          else                                            w_state_nxt = S_GAP;
        end
      end
      S_GAP:  w_state_nxt = S_HI;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Computes what the pins show during the next state; registered below.
  always_comb begin
    w_req_nxt         = 1'b0;
    w_ctrl_nxt        = 16'h0;
    w_rsp_valid_nxt   = 1'b0;
    w_rsp_ack_nxt     = r_rsp_ack;
    w_rsp_opcode_nxt  = r_rsp_opcode;
    w_rsp_retries_nxt = r_rsp_retries;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          if (w_head_nop) begin
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_ack_nxt     = 1'b1;
            w_rsp_opcode_nxt  = 3'b000;
            w_rsp_retries_nxt = 2'd0;
          end else begin
            w_req_nxt  = 1'b1;
            w_ctrl_nxt = w_head[31:16];
          end
        end
      end
      S_HI: begin
        w_req_nxt  = 1'b1;
        w_ctrl_nxt = r_cmd[15:0];
      end
      S_GAP: begin
        w_req_nxt  = 1'b1;
        w_ctrl_nxt = r_cmd[31:16];
      end
      S_DONE: begin
        w_rsp_valid_nxt   = 1'b1;
        w_rsp_ack_nxt     = r_ack;
        w_rsp_opcode_nxt  = r_cmd[31:29];
        w_rsp_retries_nxt = r_retries;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req         <= 1'b0;
      r_ctrl        <= 16'h0;
      r_rsp_valid   <= 1'b0;
      r_rsp_ack     <= 1'b0;
      r_rsp_opcode  <= 3'b000;
      r_rsp_retries <= 2'd0;
      r_busy        <= 1'b0;
    end else begin
      r_req         <= w_req_nxt;
      r_ctrl        <= w_ctrl_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_ack     <= w_rsp_ack_nxt;
      r_rsp_opcode  <= w_rsp_opcode_nxt;
      r_rsp_retries <= w_rsp_retries_nxt;
      r_busy        <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd     <= 32'h0;
      r_retries <= 2'd0;
      r_ack     <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      if (w_pop) r_cmd <= w_head;
      if (r_state == S_LO)   r_wcnt <= '0;
      if (r_state == S_WAIT) r_wcnt <= r_wcnt + 1'b1;
      if (w_last_wait) begin
        r_ack <= w_stat_bit;
        if (!w_stat_bit && (r_retries != 2'(MAX_RETRY))) r_retries <= r_retries + 2'd1;
      end
      if (r_state == S_DONE) r_retries <= 2'd0;
    end
  end

  assign o_req         = r_req;
  assign o_ctrl        = r_ctrl;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_ack     = r_rsp_ack;
  assign o_rsp_opcode  = r_rsp_opcode;
  assign o_rsp_retries = r_rsp_retries;
  assign o_busy        = r_busy;

`ifdef ATS21_ALARM_CAPTURE_EN
  logic [23:0] r_alarm_prev, r_alarm_flags;

  // A rising edge wins over a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alarm_prev  <= 24'h0;
      r_alarm_flags <= 24'h0;
    end else begin
      r_alarm_prev  <= i_alarm_data;
      r_alarm_flags <= (r_alarm_flags & ~i_alarm_clr) | (i_alarm_data & ~r_alarm_prev);
    end
  end

  assign o_alarm_flags = r_alarm_flags;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^{i_alarm_data, i_alarm_clr};
  assign o_alarm_flags  = 24'h0;
`endif

endmodule

// File: tb/tb_ats21_cmd_issuer.sv
// Bench for ats21_cmd_issuer: acts as the ATS21 stat responder and scores beats/responses against a transaction model.
module tb_ats21_cmd_issuer;

  localparam int CMD_DEPTH = 4;
  localparam int CLIENT    = 0;
  localparam int STAT_LAT  = 1;
  localparam int MAX_RETRY = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_cmd_valid;
  logic [31:0] i_cmd_data;
  logic        o_cmd_ready;
  logic        o_rsp_valid;
  logic        o_rsp_ack;
  logic [2:0]  o_rsp_opcode;
  logic [1:0]  o_rsp_retries;
  logic        o_busy;
  logic        o_req;
  logic [15:0] o_ctrl;
  logic [1:0]  i_stat;
  logic [23:0] i_alarm_data;
  logic [23:0] o_alarm_flags;
  logic [23:0] i_alarm_clr;

  ats21_cmd_issuer #(
    .CMD_DEPTH(CMD_DEPTH), .CLIENT(CLIENT), .STAT_LAT(STAT_LAT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .i_cmd_data(i_cmd_data), .o_cmd_ready(o_cmd_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_ack(o_rsp_ack), .o_rsp_opcode(o_rsp_opcode),
    .o_rsp_retries(o_rsp_retries), .o_busy(o_busy), .o_req(o_req), .o_ctrl(o_ctrl),
    .i_stat(i_stat), .i_alarm_data(i_alarm_data), .o_alarm_flags(o_alarm_flags),
    .i_alarm_clr(i_alarm_clr)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  int ack_mode = 0;      // 0 always Ack, 1 always Nack, 2 random
  int run_len = 0;
  int ctrl_idle_bad = 0;

  logic [31:0] exp_cmd_q[$];
  bit          dec_q[$];
  logic [15:0] beat_q[$];
  logic [5:0]  rsp_q[$];
  int          runs_q[$];
  logic [15:0] exp_beat_q[$];
  logic [5:0]  exp_rsp_q[$];

  // ATS21 side: collect beats and responses, answer each HI/LO pair on stat.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      run_len = 0;
      i_stat  = 2'b00;
    end else begin
      i_stat[1] = 1'($urandom_range(0, 1));
      if (o_req) begin
        beat_q.push_back(o_ctrl);
        run_len++;
        if (run_len == 2) begin
          bit d;
          d = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
          dec_q.push_back(d);
          i_stat[0] = d;
        end
      end else begin
        if (run_len != 0) runs_q.push_back(run_len);
        run_len = 0;
        if (o_ctrl != 16'h0) ctrl_idle_bad++;
      end
      if (o_rsp_valid) rsp_q.push_back({o_rsp_ack, o_rsp_opcode, o_rsp_retries});
    end
  end

  // Each non-NOP command is sent until Ack or MAX_RETRY resends are used up.
  function automatic void model_build();
    int dix, tries;
    bit d, done;
    logic [31:0] c;
    logic [2:0] op;
    dix = 0;
    exp_beat_q.delete();
    exp_rsp_q.delete();
    foreach (exp_cmd_q[k]) begin
      c = exp_cmd_q[k];
      op = c[31:29];
      if (op == 3'b000) begin
        exp_rsp_q.push_back({1'b1, 3'b000, 2'd0});
      end else begin
        tries = 0;
        done = 0;
        while (!done) begin
          exp_beat_q.push_back(c[31:16]);
          exp_beat_q.push_back(c[15:0]);
          d = (dix < dec_q.size()) ? dec_q[dix] : 1'b0;
          dix++;
          if (d) begin
            exp_rsp_q.push_back({1'b1, op, tries[1:0]});
            done = 1;
          end else if (tries == MAX_RETRY) begin
            exp_rsp_q.push_back({1'b0, op, tries[1:0]});
            done = 1;
          end else begin
            tries++;
          end
        end
      end
    end
  endfunction

  task automatic clear_q();
    exp_cmd_q.delete(); dec_q.delete(); beat_q.delete(); rsp_q.delete(); runs_q.delete();
    ctrl_idle_bad = 0;
  endtask

  // Called at a negedge; returns at the next negedge with valid dropped.
  task automatic push(input logic [31:0] d, output bit acc);
    i_cmd_valid = 1'b1;
    i_cmd_data  = d;
    acc = o_cmd_ready;
    if (acc) exp_cmd_q.push_back(d);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (!o_busy) begin ok = 1; break; end
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_data = 32'h0;
    i_alarm_data = 24'h0; i_alarm_clr = 24'h0;
    repeat (3) @(negedge i_clk);
    vectors++;
    if ({o_req, o_ctrl, o_rsp_valid, o_rsp_ack, o_rsp_opcode, o_rsp_retries, o_busy, o_cmd_ready}
        !== {1'b0, 16'h0, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%b ctrl=%h rv=%b ack=%b op=%b rt=%0d busy=%b rdy=%b, need all 0 and rdy=1",
               o_req, o_ctrl, o_rsp_valid, o_rsp_ack, o_rsp_opcode, o_rsp_retries, o_busy, o_cmd_ready);
    end
    vectors++;
    if (o_alarm_flags !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_alarm: got %h need 000000", o_alarm_flags);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_basic();
    bit acc;
    ack_mode = 0;
    clear_q();
    push(32'h2A40_0010, acc);
    vectors++;
    if ({acc, o_busy, o_req} !== 3'b110) begin
      miscompares++; $display("FAIL basic_push: acc/busy/req=%b need 110", {acc, o_busy, o_req});
    end
    @(negedge i_clk);
    vectors++;
    if ({o_req, o_ctrl} !== {1'b1, 16'h2A40}) begin
      miscompares++; $display("FAIL basic_hi: req=%b ctrl=%h need 1/2a40", o_req, o_ctrl);
    end
    @(negedge i_clk);
    vectors++;
    if ({o_req, o_ctrl} !== {1'b1, 16'h0010}) begin
      miscompares++; $display("FAIL basic_lo: req=%b ctrl=%h need 1/0010", o_req, o_ctrl);
    end
    @(negedge i_clk);
    vectors++;
    if ({o_req, o_ctrl, o_rsp_valid} !== {1'b0, 16'h0, 1'b0}) begin
      miscompares++; $display("FAIL basic_wait: req=%b ctrl=%h rv=%b need 0/0000/0", o_req, o_ctrl, o_rsp_valid);
    end
    @(negedge i_clk);
    vectors++;
    if ({o_req, o_rsp_valid} !== 2'b00) begin
      miscompares++; $display("FAIL basic_done: req/rv=%b need 00", {o_req, o_rsp_valid});
    end
    @(negedge i_clk);
    vectors++;
    if ({o_rsp_valid, o_rsp_ack, o_rsp_opcode, o_rsp_retries} !== {1'b1, 1'b1, 3'b001, 2'd0}) begin
      miscompares++;
      $display("FAIL basic_rsp: rv=%b ack=%b op=%b rt=%0d need 1/1/001/0", o_rsp_valid, o_rsp_ack, o_rsp_opcode, o_rsp_retries);
    end
    @(negedge i_clk);
    vectors++;
    if ({o_rsp_valid, o_busy} !== 2'b00) begin
      miscompares++; $display("FAIL basic_after: rv/busy=%b need 00", {o_rsp_valid, o_busy});
    end
    clear_q();
  endtask

  task automatic test_retry();
    bit acc, ok;
    ack_mode = 1;
    clear_q();
    push(32'h2A40_0010, acc);
    wait_idle(200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL retry_drain: busy stuck, need idle within 200 cycles"); end
    model_build();
    vectors++;
    if ((beat_q.size() != 6) || (exp_beat_q.size() != 6)) begin
      miscompares++; $display("FAIL retry_beats: got %0d beats need 6", beat_q.size());
    end else begin
      for (int i = 0; i < 6; i++)
        if (beat_q[i] !== exp_beat_q[i]) begin
          miscompares++; $display("FAIL retry_beat%0d: got %h need %h", i, beat_q[i], exp_beat_q[i]); break;
        end
    end
    vectors++;
    if ((rsp_q.size() != 1) || (rsp_q[0] !== {1'b0, 3'b001, 2'd2})) begin
      miscompares++;
      $display("FAIL retry_rsp: got n=%0d first=%b need n=1 {ack,op,rt}=0_001_10", rsp_q.size(),
               (rsp_q.size() > 0) ? rsp_q[0] : 6'h0);
    end
    vectors++;
    if ((runs_q.size() != 3) || (runs_q.sum() != 6)) begin
      miscompares++; $display("FAIL retry_pairs: got %0d req runs totalling %0d need 3 runs of 2", runs_q.size(), runs_q.sum());
    end
    clear_q();
  endtask

  task automatic test_nop();
    bit acc;
    clear_q();
    push(32'h0000_0000, acc);
    vectors++;
    if ({o_req, o_rsp_valid} !== 2'b00) begin
      miscompares++; $display("FAIL nop_pushed: req/rv=%b need 00", {o_req, o_rsp_valid});
    end
    @(negedge i_clk);
    vectors++;
    if ({o_req, o_rsp_valid, o_rsp_ack, o_rsp_opcode, o_rsp_retries} !== {1'b0, 1'b1, 1'b1, 3'b000, 2'd0}) begin
      miscompares++;
      $display("FAIL nop_rsp: req=%b rv=%b ack=%b op=%b rt=%0d need 0/1/1/000/0", o_req, o_rsp_valid, o_rsp_ack, o_rsp_opcode, o_rsp_retries);
    end
    @(negedge i_clk);
    vectors++;
    if ({o_req, o_rsp_valid, o_busy} !== 3'b000) begin
      miscompares++; $display("FAIL nop_after: req/rv/busy=%b need 000", {o_req, o_rsp_valid, o_busy});
    end
    clear_q();
  endtask

  task automatic test_overflow();
    bit acc, ok;
    bit rdy[5];
    logic [31:0] r;
    ack_mode = 1;
    clear_q();
    push(32'h4123_5678, acc);
    @(negedge i_clk);
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      push(r, rdy[i]);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (rdy[i] !== (i < 4)) begin
        miscompares++; $display("FAIL overflow_ready%0d: got %b need %b", i, rdy[i], (i < 4));
      end
    end
    wait_idle(400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL overflow_drain: busy stuck, need idle within 400 cycles"); end
    model_build();
    vectors++;
    if ((rsp_q.size() != 5) || (exp_rsp_q.size() != 5)) begin
      miscompares++; $display("FAIL overflow_nrsp: got %0d need 5", rsp_q.size());
    end else begin
      for (int i = 0; i < 5; i++)
        if (rsp_q[i] !== exp_rsp_q[i]) begin
          miscompares++; $display("FAIL overflow_rsp%0d: got %b need %b", i, rsp_q[i], exp_rsp_q[i]); break;
        end
    end
    clear_q();
  endtask

  task automatic test_random();
    bit acc, ok;
    logic [31:0] r;
    ack_mode = 2;
    clear_q();
    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r[31:29] = 3'b000;
      push(r, acc);
      repeat ($urandom_range(0, 6)) @(negedge i_clk);
    end
    wait_idle(2000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL random_drain: busy stuck, need idle within 2000 cycles"); end
    model_build();
    vectors++;
    if (beat_q.size() != exp_beat_q.size()) begin
      miscompares++; $display("FAIL random_nbeats: got %0d need %0d", beat_q.size(), exp_beat_q.size());
    end else begin
      foreach (beat_q[i])
        if (beat_q[i] !== exp_beat_q[i]) begin
          miscompares++; $display("FAIL random_beat%0d: got %h need %h", i, beat_q[i], exp_beat_q[i]); break;
        end
    end
    vectors++;
    if (rsp_q.size() != exp_rsp_q.size()) begin
      miscompares++; $display("FAIL random_nrsp: got %0d need %0d", rsp_q.size(), exp_rsp_q.size());
    end else begin
      foreach (rsp_q[i])
        if (rsp_q[i] !== exp_rsp_q[i]) begin
          miscompares++; $display("FAIL random_rsp%0d: got %b need %b", i, rsp_q[i], exp_rsp_q[i]); break;
        end
    end
    vectors++;
    if ((runs_q.size() * 2 != runs_q.sum()) || (ctrl_idle_bad != 0)) begin
      miscompares++;
      $display("FAIL random_req_shape: %0d runs sum %0d, ctrl nonzero with req=0 %0d times; need all runs 2 and 0",
               runs_q.size(), runs_q.sum(), ctrl_idle_bad);
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    bit acc, seen;
    ack_mode = 0;
    clear_q();
    push(32'h6ABC_1234, acc);
    repeat (2) @(negedge i_clk);
    vectors++;
    if ({o_req, o_ctrl} !== {1'b1, 16'h1234}) begin
      miscompares++; $display("FAIL midrst_lo: req=%b ctrl=%h need 1/1234", o_req, o_ctrl);
    end
    i_rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_req, o_ctrl, o_rsp_valid, o_busy, o_cmd_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_now: req=%b ctrl=%h rv=%b busy=%b rdy=%b need 0/0000/0/0/1", o_req, o_ctrl, o_rsp_valid, o_busy, o_cmd_ready);
    end
    seen = 0;
    repeat (3) begin @(negedge i_clk); if (o_rsp_valid) seen = 1; end
    i_rst_n = 1'b1;
    repeat (6) begin @(negedge i_clk); if (o_rsp_valid || o_req) seen = 1; end
    vectors++;
    if (seen || o_busy) begin
      miscompares++; $display("FAIL midrst_after: rsp/req seen=%b busy=%b need 0/0", seen, o_busy);
    end
    clear_q();
  endtask

  task automatic test_alarm();
`ifdef ATS21_ALARM_CAPTURE_EN
    bit tdat[6] = '{1, 1, 0, 0, 1, 1};
    bit tclr[6] = '{0, 0, 0, 1, 1, 0};
    bit texp[6] = '{1, 1, 1, 0, 1, 1};
    logic [23:0] m_prev, m_flags, d, c;
    for (int i = 0; i < 6; i++) begin
      i_alarm_data = 24'(tdat[i]) << 3;
      i_alarm_clr  = 24'(tclr[i]) << 3;
      @(negedge i_clk);
      vectors++;
      if (o_alarm_flags !== (24'(texp[i]) << 3)) begin
        miscompares++; $display("FAIL alarm_step%0d: got %h need %h", i, o_alarm_flags, 24'(texp[i]) << 3);
      end
    end
    m_prev  = i_alarm_data;
    m_flags = o_alarm_flags;
    for (int n = 0; n < 30; n++) begin
      d = 24'($urandom);
      c = 24'($urandom & $urandom);
      i_alarm_data = d;
      i_alarm_clr  = c;
      @(negedge i_clk);
      for (int b = 0; b < 24; b++) begin
        if (d[b] && !m_prev[b]) m_flags[b] = 1'b1;
        else if (c[b])          m_flags[b] = 1'b0;
      end
      m_prev = d;
      vectors++;
      if (o_alarm_flags !== m_flags) begin
        miscompares++; $display("FAIL alarm_rand%0d: got %h need %h", n, o_alarm_flags, m_flags);
      end
    end
`else
    for (int n = 0; n < 10; n++) begin
      i_alarm_data = 24'($urandom);
      i_alarm_clr  = 24'($urandom);
      @(negedge i_clk);
      vectors++;
      if (o_alarm_flags !== 24'h0) begin
        miscompares++; $display("FAIL alarm_off%0d: got %h need 000000", n, o_alarm_flags);
      end
    end
`endif
    i_alarm_data = 24'h0;
    i_alarm_clr  = 24'h0;
    @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_nop();
    test_overflow();
    test_random();
    test_reset_mid();
    test_alarm();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 50000 cycles");
    $fatal(1, "watchdog timeout");
  end

endmodule
